// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default rates and 8N1 frame shape.
// Pure declarations; no logic, no latency or flow control of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP,
    ST_BREAK
  } rx_state_e;

  localparam int OVERSAMPLE_DEF   = 16;
  localparam int TIMEOUT_BITS_DEF = 20;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int WORD_BITS = 2 * DATA_BITS;

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF line synchroniser (flops reset high) with a registered-history falling-edge detect.
// Edge reported 2 cycles after the line falls; no flow control, samples every cycle.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic primed_q;
  logic armed_q;

  // armed_q stays low until a real high has been captured, so a line held low
  // through reset release is not mistaken for a start edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      s1_q     <= d_i;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      primed_q <= 1'b1;
      armed_q  <= armed_q | (primed_q & s1_q);
    end
  end

  assign q_o    = s2_q;
  assign fall_o = armed_q & prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_word.sv
// Receives two back-to-back 8N1 bytes and emits one 16-bit word with a 1-cycle valid pulse.
// valid lands 1 cycle after the byte-1 stop sample; no backpressure, consumer must take the pulse.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic                 clk_153k6hz,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [WORD_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 timeout_err
);

  localparam int CW        = $clog2(OVERSAMPLE);
  localparam int GAP_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_LIMIT);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic line;
  logic fall;

  uart_rx_sync u_sync (
    .clk_i  (clk_153k6hz),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (line),
    .fall_o (fall)
  );

  rx_state_e                state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               bit_q, bit_d;
  logic                     idx_q, idx_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     byte0_q, byte0_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [WORD_BITS-1:0]     data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     terr_q, terr_d;

  always_ff @(posedge clk_153k6hz) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= 1'b0;
      shift_q <= '0;
      byte0_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte0_q <= byte0_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte0_d = byte0_q;
    gap_d   = gap_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    terr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          idx_d   = 1'b0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Falling edges here are ignored; the stop sample decides first
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!line) begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end else if (!idx_q) begin
            byte0_d = shift_q;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            data_d  = {shift_q, byte0_q};
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          idx_d   = 1'b1;
        end else if (gap_q == GAP_END) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_BREAK: begin
        if (line) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: table of word transactions plus a mid-frame reset sequence.
module tb_uart_rx_word;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  logic [15:0] data;
  logic        valid;
  logic        frame_err;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_rx_word #(
    .OVERSAMPLE   (16),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk_153k6hz (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_ferr = 0, n_terr = 0, n_overlap = 0;
  int last_valid_cyc = 0, last_terr_cyc = 0;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (timeout_err) begin
      n_terr++;
      last_terr_cyc = cyc;
    end
    if (valid && (frame_err || timeout_err)) n_overlap++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit period in hundredths of a clock cycle; fractional part accumulates
  int period = 1600;
  int acc    = 0;

  task automatic drive_bit(input logic v);
    int n;
    rx  = v;
    acc = acc + period;
    n   = acc / 100;
    acc = acc - n * 100;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        stop0;
    logic        send_b1;
    int          hold_low;
    logic        glitch;
    int          per;
    int          exp_v;
    int          exp_f;
    int          exp_t;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int v0, f0, t0, start_cyc;

    //            b0     b1     stp  b1  hold glt  per  v  f  t  data      lat
    vecs[0] = '{8'h5A, 8'hA5, 1'b1, 1'b1, 0, 1'b0, 1600, 1, 0, 0, 16'hA55A, 315};
    vecs[1] = '{8'h34, 8'h12, 1'b1, 1'b1, 0, 1'b1, 1600, 1, 0, 0, 16'h1234, 0};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b0, 50, 1'b0, 1600, 0, 1, 0, 16'h1234, 0};
    vecs[3] = '{8'h11, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1600, 0, 0, 1, 16'h1234, 476};
    vecs[4] = '{8'hEF, 8'hBE, 1'b1, 1'b1, 0, 1'b0, 1600, 1, 0, 0, 16'hBEEF, 0};
    vecs[5] = '{8'h3C, 8'hC3, 1'b1, 1'b1, 0, 1'b0, 1648, 1, 0, 0, 16'hC33C, 0};
    vecs[6] = '{8'h96, 8'h69, 1'b1, 1'b1, 0, 1'b0, 1552, 1, 0, 0, 16'h6996, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_timeout_err", int'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      v0     = n_valid;
      f0     = n_ferr;
      t0     = n_terr;
      acc    = 0;
      period = vecs[i].per;
      @(posedge clk);
      #1;
      if (vecs[i].glitch) begin
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (32) @(posedge clk);
        #1;
      end
      start_cyc = cyc;
      send_frame(vecs[i].b0, vecs[i].stop0);
      repeat (vecs[i].hold_low) drive_bit(1'b0);
      if (vecs[i].send_b1) send_frame(vecs[i].b1, 1'b1);
      repeat (26) drive_bit(1'b1);

      check($sformatf("v%0d_valid_pulses", i), n_valid - v0, vecs[i].exp_v);
      check($sformatf("v%0d_frame_err_pulses", i), n_ferr - f0, vecs[i].exp_f);
      check($sformatf("v%0d_timeout_pulses", i), n_terr - t0, vecs[i].exp_t);
      check($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_data));
      if (vecs[i].exp_lat != 0) begin
        if (vecs[i].exp_t != 0)
          check($sformatf("v%0d_timeout_latency", i), last_terr_cyc - start_cyc, vecs[i].exp_lat);
        else
          check($sformatf("v%0d_valid_latency", i), last_valid_cyc - start_cyc, vecs[i].exp_lat);
      end
    end

    // Reset while byte 1 is mid-DATA, line left low across release
    acc    = 0;
    period = 1600;
    @(posedge clk);
    #1;
    send_frame(8'h55, 1'b1);
    repeat (4) drive_bit(1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_data", int'(data), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    check("midreset_timeout_err", int'(timeout_err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = n_valid;
    f0 = n_ferr;
    t0 = n_terr;
    repeat (200) @(posedge clk);
    #1;
    check("held_low_valid", n_valid - v0, 0);
    check("held_low_frame_err", n_ferr - f0, 0);
    check("held_low_timeout", n_terr - t0, 0);
    rx = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    v0  = n_valid;
    acc = 0;
    send_frame(8'h0F, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (20) drive_bit(1'b1);
    check("post_reset_valid", n_valid - v0, 1);
    check("post_reset_data", int'(data), 16'h0F0F);

    check("valid_error_overlap", n_overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
